mem_wb: RTL and testbench

Pipeline boundary between the MEM stage and the register file. Captures MEM results each cycle, performs load-data sign/zero extension and LWL/LWR merging, and drives the register-file write port, the HI/LO write port and the LL bit. Honours the pipeline stall vector and the exception flush so that only retired results reach architectural state.

---
 rtl/mem_wb_pkg.sv | 22 ++
 rtl/mem_wb_load_align.sv | 43 ++++
 rtl/mem_wb.sv | 82 ++++++++
 tb/tb_mem_wb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared constants and load-op encoding for the MEM/WB boundary
package mem_wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [DATA_W-1:0] ZeroWord = '0;
  localparam logic [ADDR_W-1:0] NOPRegAddr = '0;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5,
    LOAD_LWL  = 3'd6,
    LOAD_LWR  = 3'd7
  } load_op_e;
endpackage

// File: rtl/mem_wb_load_align.sv
// load_align: big-endian load extraction, sign/zero extension and LWL/LWR merge
//   mem_load_op  : load kind (LOAD_* encoding)
//   mem_byte_off : effective address [1:0], offset 0 addresses bits 31:24
//   mem_rdata    : word from data memory
//   mem_wdata    : ALU result, or old rt value for LWL/LWR merges
//   aligned      : value destined for the register file
module load_align
  import mem_wb_pkg::*;
(
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] aligned
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_half_ok;
  // big-endian: byte k lives at bit 8*(3-k), and 3-k == ~k for two bits
  assign w_byte    = mem_rdata[{~mem_byte_off, 3'b000} +: 8];
  assign w_half    = mem_byte_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  // misaligned halfword yields zero; the AdEL flush discards it anyway
  assign w_half_ok = ~mem_byte_off[0];
  always_comb begin
    aligned = mem_wdata;
    case (load_op_e'(mem_load_op))
      LOAD_LB:  aligned = {{24{w_byte[7]}}, w_byte};
      LOAD_LBU: aligned = {24'b0, w_byte};
      LOAD_LH:  aligned = w_half_ok ? {{16{w_half[15]}}, w_half} : ZeroWord;
      LOAD_LHU: aligned = w_half_ok ? {16'b0, w_half} : ZeroWord;
      LOAD_LW:  aligned = mem_rdata;
      LOAD_LWL: aligned = mem_byte_off == 2'd0 ? mem_rdata :
                          mem_byte_off == 2'd1 ? {mem_rdata[23:0], mem_wdata[7:0]} :
                          mem_byte_off == 2'd2 ? {mem_rdata[15:0], mem_wdata[15:0]} :
                                                 {mem_rdata[7:0], mem_wdata[23:0]};
      LOAD_LWR: aligned = mem_byte_off == 2'd0 ? {mem_wdata[31:8], mem_rdata[31:24]} :
                          mem_byte_off == 2'd1 ? {mem_wdata[31:16], mem_rdata[31:16]} :
                          mem_byte_off == 2'd2 ? {mem_wdata[31:24], mem_rdata[31:8]} :
                                                 mem_rdata;
      default:  aligned = mem_wdata;
    endcase
  end
endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register driving GPR, HI/LO and LL-bit state
//   clk, rst         : clock, synchronous active-high reset
//   stall, flush     : stall vector (bit 4 MEM, bit 5 WB) and exception flush
//   mem_*            : MEM-stage results, load control and LL/SC update
//   wb_we/waddr/wdata: register-file write port
//   wb_whilo/hi/lo   : HI/LO write port
//   llbit            : current LL bit
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic          mem_wreg,
  input  logic [AW-1:0] mem_wd,
  input  logic [DW-1:0] mem_wdata,
  input  logic [2:0]    mem_load_op,
  input  logic [1:0]    mem_byte_off,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_whilo,
  input  logic [DW-1:0] mem_hi,
  input  logic [DW-1:0] mem_lo,
  input  logic          mem_llbit_we,
  input  logic          mem_llbit_value,
  output logic          wb_we,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_whilo,
  output logic [DW-1:0] wb_hi,
  output logic [DW-1:0] wb_lo,
  output logic          llbit
);
  logic          r_we, r_whilo, r_llbit;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata, r_hi, r_lo;
  logic [DW-1:0] w_aligned;
  logic          w_bubble, w_capture;
  logic          w_unused;
  assign w_unused  = ^stall[3:0];
  assign w_bubble  = stall[STALL_MEM] & ~stall[STALL_WB];
  assign w_capture = ~stall[STALL_MEM];
  load_align u_align (
    .mem_load_op (mem_load_op),
    .mem_byte_off(mem_byte_off),
    .mem_rdata   (mem_rdata),
    .mem_wdata   (mem_wdata),
    .aligned     (w_aligned)
  );
  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush || w_bubble) begin
      r_we    <= WriteDisable;
      r_waddr <= NOPRegAddr;
      r_wdata <= ZeroWord;
      r_whilo <= WriteDisable;
      r_hi    <= ZeroWord;
      r_lo    <= ZeroWord;
    end else if (w_capture) begin
      r_we    <= mem_wreg;
      r_waddr <= mem_wd;
      r_wdata <= w_aligned;
      r_whilo <= mem_whilo;
      r_hi    <= mem_hi;
      r_lo    <= mem_lo;
    end
  end
  // a flushed LL/SC must not leave a reservation behind; bubbles and holds keep it
  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) r_llbit <= 1'b0;
    else if (w_capture && mem_llbit_we) r_llbit <= mem_llbit_value;
  end
  assign wb_we    = r_we;
  assign wb_waddr = r_waddr;
  assign wb_wdata = r_wdata;
  assign wb_whilo = r_whilo;
  assign wb_hi    = r_hi;
  assign wb_lo    = r_lo;
  assign llbit    = r_llbit;
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: randomized self-checking bench for mem_wb against a behavioural model
module tb_mem_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        mem_wreg = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_load_op = '0;
  logic [1:0]  mem_byte_off = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_whilo = 1'b0;
  logic [31:0] mem_hi = '0, mem_lo = '0;
  logic        mem_llbit_we = 1'b0, mem_llbit_value = 1'b0;
  logic        wb_we, wb_whilo, llbit;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        e_we = 0, e_whilo = 0, e_ll = 0;
  logic [4:0]  e_waddr = 0;
  logic [31:0] e_wdata = 0, e_hi = 0, e_lo = 0;
  int n_chk = 0, n_fail = 0;
  wire [103:0] obs  = {wb_we, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo, llbit};
  wire [103:0] expv = {e_we, e_waddr, e_wdata, e_whilo, e_hi, e_lo, e_ll};

  mem_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_load_op(mem_load_op), .mem_byte_off(mem_byte_off), .mem_rdata(mem_rdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .llbit(llbit)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input int op, input int off,
                                           input logic [31:0] m, input logic [31:0] r);
    logic [63:0] mm, rr, v;
    logic [31:0] b, h;
    mm = {32'b0, m};
    rr = {32'b0, r};
    b = (m >> (8 * (3 - off))) & 32'hFF;
    h = (m >> (16 - 8 * (off & 2))) & 32'hFFFF;
    case (op)
      1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      2: return b;
      3: return (off % 2 != 0) ? 32'h0 : ((h >= 32768) ? h + 32'hFFFF_0000 : h);
      4: return (off % 2 != 0) ? 32'h0 : h;
      5: return m;
      6: begin
        v = (mm << (8 * off)) | (rr & ((64'd1 << (8 * off)) - 1));
        return v[31:0];
      end
      7: begin
        v = (mm >> (8 * (3 - off))) | (rr & ~((64'd1 << (8 * (off + 1))) - 1));
        return v[31:0];
      end
      default: return r;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      {e_we, e_waddr, e_wdata, e_whilo, e_hi, e_lo, e_ll} = '0;
    end else if (flush || (stall[4] && !stall[5])) begin
      {e_we, e_waddr, e_wdata, e_whilo, e_hi, e_lo} = '0;
      if (flush) e_ll = 1'b0;
    end else if (!stall[4]) begin
      e_we = mem_wreg;
      e_waddr = mem_wd;
      e_wdata = ref_load(int'(mem_load_op), int'(mem_byte_off), mem_rdata, mem_wdata);
      e_whilo = mem_whilo;
      e_hi = mem_hi;
      e_lo = mem_lo;
      if (mem_llbit_we) e_ll = mem_llbit_value;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    mem_wreg = 1'($urandom);
    mem_wd = 5'($urandom);
    mem_wdata = $urandom;
    mem_load_op = 3'($urandom);
    mem_byte_off = 2'($urandom);
    mem_rdata = $urandom;
    mem_whilo = 1'($urandom);
    mem_hi = $urandom;
    mem_lo = $urandom;
    mem_llbit_we = 1'($urandom);
    mem_llbit_value = 1'($urandom);
  endtask

  task automatic set_plain(input logic [4:0] wd, input logic [31:0] d);
    mem_wreg = 1; mem_wd = wd; mem_wdata = d; mem_load_op = 0;
    mem_whilo = 0; mem_hi = 0; mem_lo = 0; mem_llbit_we = 0; mem_llbit_value = 0;
  endtask

  task automatic test_reset();
    rst = 1; stall = 6'($urandom); flush = 1'($urandom);
    rand_inputs(); tick();
    rand_inputs(); tick();
    n_chk++;
    if (obs !== 104'h0) begin n_fail++; $display("FAIL reset_zero got=%h exp=0", obs); end
    rst = 0; stall = 0; flush = 0;
    set_plain(5'd5, 32'h1234_5678);
    tick();
    n_chk++;
    if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      n_fail++; $display("FAIL first_capture got=%b/%0d/%h exp=1/5/12345678", wb_we, wb_waddr, wb_wdata);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  k_op[5]  = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4};
    logic [1:0]  k_off[5] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd0};
    logic [31:0] k_val[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001, 32'h0000_7F01, 32'h0000_80FF};
    set_plain(5'd9, 32'h5555_5555);
    mem_rdata = 32'h80FF_7F01;
    for (int op = 1; op <= 4; op++)
      for (int off = 0; off < 4; off += (op >= 3 ? 2 : 1)) begin
        mem_load_op = 3'(op); mem_byte_off = 2'(off);
        tick();
        n_chk++;
        if (obs !== expv) begin n_fail++; $display("FAIL load_ext op=%0d off=%0d got=%h exp=%h", op, off, obs, expv); end
      end
    for (int i = 0; i < 5; i++) begin
      mem_load_op = k_op[i]; mem_byte_off = k_off[i];
      tick();
      n_chk++;
      if (wb_wdata !== k_val[i]) begin n_fail++; $display("FAIL load_ext_k%0d got=%h exp=%h", i, wb_wdata, k_val[i]); end
    end
  endtask

  task automatic test_merge();
    logic [2:0]  k_op[4]  = '{3'd6, 3'd6, 3'd7, 3'd7};
    logic [1:0]  k_off[4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic [31:0] k_val[4] = '{32'h2233_44DD, 32'h44BB_CCDD, 32'hAABB_CC11, 32'hAA11_2233};
    set_plain(5'd3, 32'hAABB_CCDD);
    mem_rdata = 32'h1122_3344;
    for (int i = 0; i < 4; i++) begin
      mem_load_op = k_op[i]; mem_byte_off = k_off[i];
      tick();
      n_chk++;
      if (wb_wdata !== k_val[i]) begin n_fail++; $display("FAIL merge_k%0d got=%h exp=%h", i, wb_wdata, k_val[i]); end
    end
    for (int op = 6; op <= 7; op++)
      for (int off = 0; off < 4; off++) begin
        mem_load_op = 3'(op); mem_byte_off = 2'(off);
        tick();
        n_chk++;
        if (obs !== expv) begin n_fail++; $display("FAIL merge op=%0d off=%0d got=%h exp=%h", op, off, obs, expv); end
      end
  endtask

  task automatic test_stall();
    set_plain(5'd7, 32'hCAFE_0001);
    tick();
    stall = 6'b010000;
    set_plain(5'd8, 32'h1111_2222);
    tick();
    n_chk++;
    if ({wb_we, wb_wdata} !== 33'h0) begin n_fail++; $display("FAIL bubble got=%b/%h exp=0/0", wb_we, wb_wdata); end
    stall = 0;
    set_plain(5'd10, 32'h0BAD_F00D);
    tick();
    stall = 6'b110000;
    set_plain(5'd11, 32'h9999_9999);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd10, 32'h0BAD_F00D}) begin
        n_fail++; $display("FAIL hold%0d got=%b/%0d/%h exp=1/10/0badf00d", i, wb_we, wb_waddr, wb_wdata);
      end
    end
    stall = 0;
    tick();
    n_chk++;
    if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd11, 32'h9999_9999}) begin
      n_fail++; $display("FAIL resume got=%b/%0d/%h exp=1/11/99999999", wb_we, wb_waddr, wb_wdata);
    end
    stall = 6'b110000;
    tick();
    rst = 1;
    tick();
    rst = 0;
    n_chk++;
    if (obs !== 104'h0) begin n_fail++; $display("FAIL rst_in_hold got=%h exp=0", obs); end
    stall = 0;
  endtask

  task automatic test_flush_ll();
    set_plain(5'd4, 32'h0000_4444);
    mem_llbit_we = 1; mem_llbit_value = 1;
    tick();
    n_chk++;
    if (llbit !== 1'b1) begin n_fail++; $display("FAIL ll_set got=%b exp=1", llbit); end
    stall = 6'b010000; mem_llbit_value = 0;
    tick();
    n_chk++;
    if (llbit !== 1'b1) begin n_fail++; $display("FAIL ll_keep_bubble got=%b exp=1", llbit); end
    stall = 0; flush = 1; mem_llbit_value = 1;
    tick();
    n_chk++;
    if (obs !== 104'h0) begin n_fail++; $display("FAIL flush_ll got=%h exp=0", obs); end
    flush = 0; mem_llbit_we = 0;
    set_plain(5'd12, 32'h7777_0000);
    tick();
    stall = 6'b110000; flush = 1;
    tick();
    n_chk++;
    if (obs !== 104'h0) begin n_fail++; $display("FAIL flush_in_hold got=%h exp=0", obs); end
    stall = 0; flush = 0;
  endtask

  task automatic test_hilo();
    set_plain(5'd0, 32'h0);
    mem_wreg = 0; mem_whilo = 1; mem_hi = 32'hDEAD_BEEF; mem_lo = 32'h0000_0001;
    tick();
    n_chk++;
    if ({wb_whilo, wb_hi, wb_lo} !== {1'b1, 32'hDEAD_BEEF, 32'h0000_0001}) begin
      n_fail++; $display("FAIL hilo got=%b/%h/%h exp=1/deadbeef/00000001", wb_whilo, wb_hi, wb_lo);
    end
    stall = 6'b010000;
    tick();
    n_chk++;
    if (wb_whilo !== 1'b0) begin n_fail++; $display("FAIL hilo_bubble got=%b exp=0", wb_whilo); end
    stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 40) == 0;
      flush = ($urandom % 12) == 0;
      stall = {1'($urandom), ($urandom % 3) == 0, 4'($urandom)};
      rand_inputs();
      tick();
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL random%0d got=%h exp=%h", i, obs, expv); end
    end
    rst = 0; flush = 0; stall = 0;
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_merge();
    test_stall();
    test_flush_ll();
    test_hilo();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
